// File: rtl/openadc_cmd_parser.sv
// openadc_cmd_parser
// Byte-stream command parser in front of the OpenADC register block.
// Frame: [1 RW A5..A0][SIZE_L][SIZE_H][payload][checksum], checksum is the
// mod-256 sum of every byte before it (read payload = bytes sent to host).
// Optional inter-byte timeout: define CMD_TIMEOUT_EN (uses TIMEOUT_CYCLES).
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | hunting for a header byte (bit7=1), others discarded
// ST_SIZE_L   | waiting for low size byte
// ST_SIZE_H   | waiting for high size byte, then size/addrvalid committed
// ST_WR_DATA  | each rx byte becomes one reg_write pulse
// ST_WR_CHK   | waiting for host checksum, mismatch pulses chk_err
// ST_RD_SETUP | one settle cycle before the read strobe
// ST_RD_FETCH | reg_read high, reg_datao captured into tx_data
// ST_RD_SEND  | holding tx byte until the sink accepts it
// ST_RD_CHK   | sending running checksum to the host

module openadc_cmd_parser #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [5:0]  reg_address,
   output logic [15:0] reg_bytecnt,
   output logic [7:0]  reg_datai,
   input  logic [7:0]  reg_datao,
   output logic [15:0] reg_size,
   output logic        reg_read,
   output logic        reg_write,
   output logic        reg_addrvalid,
   output logic [5:0]  reg_hypaddress,
   input  logic [15:0] reg_hyplen,
   output logic        chk_err
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SIZE_L,
      ST_SIZE_H,
      ST_WR_DATA,
      ST_WR_CHK,
      ST_RD_SETUP,
      ST_RD_FETCH,
      ST_RD_SEND,
      ST_RD_CHK
   } state_t;

   state_t      state_q;
   logic        rw_q;
   logic [7:0]  size_l_q;
   logic [7:0]  csum_q;
   logic [7:0]  tx_data_q;
   logic        tx_valid_q;
   logic [5:0]  reg_address_q;
   logic [15:0] reg_bytecnt_q;
   logic [7:0]  reg_datai_q;
   logic [15:0] reg_size_q;
   logic        reg_read_q;
   logic        reg_write_q;
   logic        reg_addrvalid_q;
   logic [5:0]  reg_hypaddress_q;
   logic        chk_err_q;

   logic [15:0] size_hdr_d;
   logic [15:0] size_eff_d;
   logic [15:0] wr_idx_d;
   logic [7:0]  csum_rx_d;
   logic [7:0]  csum_rd_d;
   logic        last_byte_d;
   logic        last_wr_d;

`ifdef CMD_TIMEOUT_EN
   logic [23:0] tmo_q;
   logic        timed_d;
`endif

   // Next-value helpers: header size, natural-size substitution, write index
   // (bytecnt advances the cycle after each write pulse, so a back-to-back
   // byte must use the already-advanced index) and running checksums.
   always_comb begin
      size_hdr_d  = {rx_data, size_l_q};
      size_eff_d  = (rw_q && (size_hdr_d == 16'd0)) ? reg_hyplen : size_hdr_d;
      wr_idx_d    = reg_write_q ? (reg_bytecnt_q + 16'd1) : reg_bytecnt_q;
      csum_rx_d   = csum_q + rx_data;
      csum_rd_d   = csum_q + reg_datao;
      last_byte_d = (reg_bytecnt_q == (reg_size_q - 16'd1));
      last_wr_d   = (wr_idx_d == (reg_size_q - 16'd1));
`ifdef CMD_TIMEOUT_EN
      timed_d     = (state_q == ST_SIZE_L) || (state_q == ST_SIZE_H) ||
                    (state_q == ST_WR_DATA) || (state_q == ST_WR_CHK);
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         rw_q             <= 1'b0;
         size_l_q         <= 8'd0;
         csum_q           <= 8'd0;
         tx_data_q        <= 8'd0;
         tx_valid_q       <= 1'b0;
         reg_address_q    <= 6'd0;
         reg_bytecnt_q    <= 16'd0;
         reg_datai_q      <= 8'd0;
         reg_size_q       <= 16'd0;
         reg_read_q       <= 1'b0;
         reg_write_q      <= 1'b0;
         reg_addrvalid_q  <= 1'b0;
         reg_hypaddress_q <= 6'd0;
         chk_err_q        <= 1'b0;
`ifdef CMD_TIMEOUT_EN
         tmo_q            <= 24'd0;
`endif
      end else begin
         reg_write_q <= 1'b0;
         reg_read_q  <= 1'b0;
         chk_err_q   <= 1'b0;
         if (reg_write_q) begin
            reg_bytecnt_q <= reg_bytecnt_q + 16'd1;
         end

         case (state_q)
            ST_IDLE: begin
               if (rx_valid && rx_data[7]) begin
                  rw_q             <= rx_data[6];
                  reg_address_q    <= rx_data[5:0];
                  reg_hypaddress_q <= rx_data[5:0];
                  csum_q           <= rx_data;
                  state_q          <= ST_SIZE_L;
               end
            end
            ST_SIZE_L: begin
               if (rx_valid) begin
                  size_l_q <= rx_data;
                  csum_q   <= csum_rx_d;
                  state_q  <= ST_SIZE_H;
               end
            end
            ST_SIZE_H: begin
               if (rx_valid) begin
                  csum_q          <= csum_rx_d;
                  reg_size_q      <= size_eff_d;
                  reg_addrvalid_q <= 1'b1;
                  reg_bytecnt_q   <= 16'd0;
                  if (!rw_q) begin
                     state_q <= (size_eff_d == 16'd0) ? ST_WR_CHK : ST_WR_DATA;
                  end else if (size_eff_d == 16'd0) begin
                     tx_data_q  <= csum_rx_d;
                     tx_valid_q <= 1'b1;
                     state_q    <= ST_RD_CHK;
                  end else begin
                     state_q <= ST_RD_SETUP;
                  end
               end
            end
            ST_WR_DATA: begin
               if (rx_valid) begin
                  reg_datai_q   <= rx_data;
                  reg_write_q   <= 1'b1;
                  reg_bytecnt_q <= wr_idx_d;
                  csum_q        <= csum_rx_d;
                  if (last_wr_d) begin
                     state_q <= ST_WR_CHK;
                  end
               end
            end
            ST_WR_CHK: begin
               if (rx_valid) begin
                  chk_err_q       <= (rx_data != csum_q);
                  reg_addrvalid_q <= 1'b0;
                  state_q         <= ST_IDLE;
               end
            end
            ST_RD_SETUP: begin
               reg_read_q <= 1'b1;
               state_q    <= ST_RD_FETCH;
            end
            ST_RD_FETCH: begin
               tx_data_q  <= reg_datao;
               tx_valid_q <= 1'b1;
               csum_q     <= csum_rd_d;
               state_q    <= ST_RD_SEND;
            end
            ST_RD_SEND: begin
               if (tx_ready) begin
                  if (last_byte_d) begin
                     tx_data_q <= csum_q;
                     state_q   <= ST_RD_CHK;
                  end else begin
                     tx_valid_q    <= 1'b0;
                     reg_bytecnt_q <= reg_bytecnt_q + 16'd1;
                     state_q       <= ST_RD_SETUP;
                  end
               end
            end
            ST_RD_CHK: begin
               if (tx_ready) begin
                  tx_valid_q      <= 1'b0;
                  reg_addrvalid_q <= 1'b0;
                  state_q         <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase

`ifdef CMD_TIMEOUT_EN
         if (rx_valid || !timed_d) begin
            tmo_q <= 24'd0;
         end else if (tmo_q == (TIMEOUT_CYCLES - 24'd1)) begin
            tmo_q           <= 24'd0;
            reg_addrvalid_q <= 1'b0;
            state_q         <= ST_IDLE;
         end else begin
            tmo_q <= tmo_q + 24'd1;
         end
`endif
      end
   end

   assign tx_data        = tx_data_q;
   assign tx_valid       = tx_valid_q;
   assign reg_address    = reg_address_q;
   assign reg_bytecnt    = reg_bytecnt_q;
   assign reg_datai      = reg_datai_q;
   assign reg_size       = reg_size_q;
   assign reg_read       = reg_read_q;
   assign reg_write      = reg_write_q;
   assign reg_addrvalid  = reg_addrvalid_q;
   assign reg_hypaddress = reg_hypaddress_q;
   assign chk_err        = chk_err_q;

endmodule

// File: tb/tb_openadc_cmd_parser.sv
// Directed bench for openadc_cmd_parser.
// Register block model: natural length 4 at address 5 (else 0),
// read data = bytecnt + 0x10.
module tb_openadc_cmd_parser;

   logic        clk;
   logic        reset_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [5:0]  reg_address;
   logic [15:0] reg_bytecnt;
   logic [7:0]  reg_datai;
   logic [7:0]  reg_datao;
   logic [15:0] reg_size;
   logic        reg_read;
   logic        reg_write;
   logic        reg_addrvalid;
   logic [5:0]  reg_hypaddress;
   logic [15:0] reg_hyplen;
   logic        chk_err;

   int n_pass  = 0;
   int n_total = 0;

   int          wr_cnt  = 0;
   int          rd_cnt  = 0;
   int          chk_cnt = 0;
   logic [5:0]  wr_addr = '0;
   logic [15:0] wr_bc   = '0;
   logic [7:0]  wr_data = '0;
   logic [7:0]  wr_prev = '0;

   openadc_cmd_parser #(.TIMEOUT_CYCLES(24'd100)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .reg_address    (reg_address),
      .reg_bytecnt    (reg_bytecnt),
      .reg_datai      (reg_datai),
      .reg_datao      (reg_datao),
      .reg_size       (reg_size),
      .reg_read       (reg_read),
      .reg_write      (reg_write),
      .reg_addrvalid  (reg_addrvalid),
      .reg_hypaddress (reg_hypaddress),
      .reg_hyplen     (reg_hyplen),
      .chk_err        (chk_err)
   );

   assign reg_hyplen = (reg_hypaddress == 6'd5) ? 16'd4 : 16'd0;
   assign reg_datao  = reg_bytecnt[7:0] + 8'h10;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reg_write) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= reg_address;
         wr_bc   <= reg_bytecnt;
         wr_prev <= wr_data;
         wr_data <= reg_datai;
      end
      if (reg_read) rd_cnt <= rd_cnt + 1;
      if (chk_err) chk_cnt <= chk_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1 rx_data = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input string tag);
      int k;
      k = 0;
      while (!tx_valid && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({tag, " tx_valid"}, {31'd0, tx_valid}, 32'd1);
   endtask

   task automatic accept();
      tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
   endtask

   logic [7:0] exp_csum;
   logic [7:0] exp_b;

   initial begin
      reset_n  = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      idle(3);
      check("rst tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst tx_data", {24'd0, tx_data}, 32'd0);
      check("rst addrvalid", {31'd0, reg_addrvalid}, 32'd0);
      check("rst size", {16'd0, reg_size}, 32'd0);
      check("rst write", {31'd0, reg_write}, 32'd0);
      check("rst chk_err", {31'd0, chk_err}, 32'd0);
      reset_n = 1'b1;
      idle(2);

      send(8'h80); send(8'h01); send(8'h00);
      check("wr1 addrvalid", {31'd0, reg_addrvalid}, 32'd1);
      check("wr1 size", {16'd0, reg_size}, 32'd1);
      send(8'h5A); send(8'hDB);
      idle(3);
      check("wr1 count", wr_cnt, 1);
      check("wr1 addr", {26'd0, wr_addr}, 32'd0);
      check("wr1 data", {24'd0, wr_data}, 32'h5A);
      check("wr1 bytecnt", {16'd0, wr_bc}, 32'd0);
      check("wr1 chk_err", chk_cnt, 0);
      check("wr1 addrvalid end", {31'd0, reg_addrvalid}, 32'd0);

      send(8'h80); send(8'h01); send(8'h00); send(8'h5A); send(8'h00);
      idle(3);
      check("wr2 count", wr_cnt, 2);
      check("wr2 chk_err", chk_cnt, 1);

      send(8'hC5); send(8'h00); send(8'h00);
      check("rd1 size", {16'd0, reg_size}, 32'd4);
      check("rd1 hypaddr", {26'd0, reg_hypaddress}, 32'd5);
      exp_csum = 8'hC5;
      for (int i = 0; i < 4; i++) begin
         exp_b = 8'h10 + i[7:0];
         exp_csum = exp_csum + exp_b;
         wait_tx("rd1 byte");
         check("rd1 data", {24'd0, tx_data}, {24'd0, exp_b});
         if (i == 1) begin
            idle(48);
            send(8'h80);
            check("stall data", {24'd0, tx_data}, 32'h11);
            check("stall valid", {31'd0, tx_valid}, 32'd1);
            check("stall bytecnt", {16'd0, reg_bytecnt}, 32'd1);
            check("stall reads", rd_cnt, 2);
         end
         accept();
      end
      wait_tx("rd1 csum");
      check("rd1 csum", {24'd0, tx_data}, {24'd0, exp_csum});
      accept();
      idle(2);
      check("rd1 reads", rd_cnt, 4);
      check("rd1 tx_valid end", {31'd0, tx_valid}, 32'd0);
      check("rd1 addrvalid end", {31'd0, reg_addrvalid}, 32'd0);

      send(8'h12); send(8'h34);
      send(8'h83); send(8'h02); send(8'h00);
      @(posedge clk);
      #1 rx_data = 8'hA1;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_data = 8'hB2;
      @(posedge clk);
      #1 rx_valid = 1'b0;
      send(8'hD8);
      idle(3);
      check("wr3 count", wr_cnt, 4);
      check("wr3 addr", {26'd0, wr_addr}, 32'd3);
      check("wr3 first data", {24'd0, wr_prev}, 32'hA1);
      check("wr3 last data", {24'd0, wr_data}, 32'hB2);
      check("wr3 last bytecnt", {16'd0, wr_bc}, 32'd1);
      check("wr3 chk_err", chk_cnt, 1);

      send(8'h84); send(8'h00); send(8'h00); send(8'h84);
      idle(3);
      check("wr0 count", wr_cnt, 4);
      check("wr0 chk_err", chk_cnt, 1);
      check("wr0 addrvalid end", {31'd0, reg_addrvalid}, 32'd0);

      send(8'hC5); send(8'h02); send(8'h00);
      check("rd2 size", {16'd0, reg_size}, 32'd2);
      exp_csum = 8'hC5 + 8'h02;
      for (int i = 0; i < 2; i++) begin
         exp_b = 8'h10 + i[7:0];
         exp_csum = exp_csum + exp_b;
         wait_tx("rd2 byte");
         check("rd2 data", {24'd0, tx_data}, {24'd0, exp_b});
         accept();
      end
      wait_tx("rd2 csum");
      check("rd2 csum", {24'd0, tx_data}, {24'd0, exp_csum});
      accept();
      idle(2);
      check("rd2 reads", rd_cnt, 6);

      send(8'hC5); send(8'h00); send(8'h00);
      wait_tx("rd3 byte");
      reset_n = 1'b0;
      idle(1);
      check("rstmid tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rstmid addrvalid", {31'd0, reg_addrvalid}, 32'd0);
      reset_n = 1'b1;
      send(8'h81); send(8'h01); send(8'h00); send(8'h33); send(8'hB5);
      idle(3);
      check("wr4 count", wr_cnt, 5);
      check("wr4 addr", {26'd0, wr_addr}, 32'd1);
      check("wr4 data", {24'd0, wr_data}, 32'h33);
      check("wr4 chk_err", chk_cnt, 1);

`ifdef CMD_TIMEOUT_EN
      send(8'h81); send(8'h02);
      idle(110);
      check("tmo no write", wr_cnt, 5);
      check("tmo addrvalid", {31'd0, reg_addrvalid}, 32'd0);
      send(8'h82); send(8'h01); send(8'h00); send(8'h44); send(8'hC7);
      idle(3);
      check("tmo wr count", wr_cnt, 6);
      check("tmo wr addr", {26'd0, wr_addr}, 32'd2);
      check("tmo wr data", {24'd0, wr_data}, 32'h44);
      check("tmo chk_err", chk_cnt, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
